// File: rtl/affine_pkg.sv
// affine_pkg: shared constants, state encoding and word type for the affine op2 loader
package affine_pkg;
  localparam int AFFINE_WIDTH = 12;
  localparam int AFFINE_NWORDS = 16;
  typedef enum logic {ST_FILL, ST_FULL} state_t;
  typedef logic [AFFINE_WIDTH-1:0] word_t;
endpackage

// File: rtl/affine_op2_loader.sv
// affine_op2_loader: collects NWORDS serial words into one frame for the second-stage adder; ports clock/reset, in_data/in_valid/in_first/in_ready, out_data/out_valid/out_ready, sync_err, out_sum only with AFFINE_OP2_LOADER_SUM_EN
module affine_op2_loader
  import affine_pkg::*;
#(
  parameter int WIDTH = AFFINE_WIDTH,
  parameter int NWORDS = AFFINE_NWORDS,
  parameter int IDXW = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [WIDTH-1:0]        in_data,
  input  logic                    in_valid,
  input  logic                    in_first,
  output logic                    in_ready,
  output logic [WIDTH*NWORDS-1:0] out_data,
`ifdef AFFINE_OP2_LOADER_SUM_EN
  output logic [WIDTH-1:0]        out_sum,
`endif
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sync_err
);
  state_t                  r_state;
  logic [IDXW-1:0]         r_idx;
  logic [WIDTH*NWORDS-1:0] r_buf;
  logic                    r_sync_err;
  logic                    w_acc;
  logic                    w_resync;
  logic [IDXW-1:0]         w_widx;
  assign in_ready = r_state == ST_FILL;
  assign out_valid = r_state == ST_FULL;
  assign out_data = r_buf;
  assign sync_err = r_sync_err;
  assign w_acc = in_valid && in_ready;
  assign w_resync = w_acc && in_first && r_idx != '0;
  // a resync restarts the frame, so the word lands in slot 0
  assign w_widx = w_resync ? '0 : r_idx;
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_FILL;
      r_idx <= '0;
      r_buf <= '0;
      r_sync_err <= 1'b0;
    end else begin
      r_sync_err <= w_resync;
      if (w_acc) begin
        r_buf[w_widx*WIDTH +: WIDTH] <= in_data;
        if (w_widx == IDXW'(NWORDS-1)) begin
          r_state <= ST_FULL;
          r_idx <= '0;
        end else r_idx <= w_widx + 1'b1;
      end else if (out_valid && out_ready) r_state <= ST_FILL;
    end
  end
`ifdef AFFINE_OP2_LOADER_SUM_EN
  logic [WIDTH+IDXW-1:0] r_acc;
  logic [WIDTH+IDXW-1:0] w_ext;
  assign w_ext = {{IDXW{1'b0}}, in_data};
  // divide-by-8 matches the second-stage adder scaling
  assign out_sum = r_acc[WIDTH+2:3];
  always_ff @(posedge clock) begin
    if (reset) r_acc <= '0;
    else if (w_acc) r_acc <= (w_widx == '0) ? w_ext : r_acc + w_ext;
  end
`endif
endmodule

// File: tb/tb_affine_op2_loader.sv
// tb_affine_op2_loader: directed self-checking bench for affine_op2_loader
module tb_affine_op2_loader;
  logic         clock = 0;
  logic         reset = 1;
  logic [11:0]  in_data = 0;
  logic         in_valid = 0;
  logic         in_first = 0;
  logic         in_ready;
  logic [191:0] out_data;
  logic         out_valid;
  logic         out_ready = 0;
  logic         sync_err;
  logic [191:0] exp_frame;
  int           n_chk = 0;
  int           n_pass = 0;
`ifdef AFFINE_OP2_LOADER_SUM_EN
  logic [11:0]  out_sum;
`endif
  affine_op2_loader dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_first(in_first), .in_ready(in_ready), .out_data(out_data),
`ifdef AFFINE_OP2_LOADER_SUM_EN
    .out_sum(out_sum),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .sync_err(sync_err)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask
  task automatic push(input logic [11:0] d, input logic f);
    int n = 0;
    in_data = d;
    in_first = f;
    in_valid = 1;
    while (!in_ready && n < 50) begin
      tick(1);
      n++;
    end
    if (!in_ready) check("push_timeout", 0, 1);
    tick(1);
    in_valid = 0;
    in_first = 0;
  endtask
  task automatic pop();
    out_ready = 1;
    tick(1);
    out_ready = 0;
  endtask
  task automatic do_reset();
    reset = 1;
    tick(1);
    reset = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    tick(2);
    reset = 0;
    check("rst_valid", out_valid, 0);
    check("rst_ready", in_ready, 1);
    check("rst_data", out_data, 0);
    check("rst_err", sync_err, 0);
    for (int k = 0; k < 16; k++) exp_frame[k*12 +: 12] = 12'(k + 1);
    for (int k = 0; k < 15; k++) push(12'(k + 1), k == 0);
    check("first_no_err", sync_err, 0);
    check("valid_before_last", out_valid, 0);
    push(12'd16, 0);
    check("full_valid", out_valid, 1);
    check("full_ready", in_ready, 0);
    check("frame_seq", out_data, exp_frame);
`ifdef AFFINE_OP2_LOADER_SUM_EN
    check("sum_seq", out_sum, 12'd17);
`endif
    tick(10);
    check("hold_valid", out_valid, 1);
    check("hold_data", out_data, exp_frame);
    pop();
    check("pop_valid", out_valid, 0);
    check("pop_ready", in_ready, 1);
    for (int k = 0; k < 16; k++) push(12'hFFF, 0);
    check("ones_valid", out_valid, 1);
    check("ones_data", out_data, {192{1'b1}});
`ifdef AFFINE_OP2_LOADER_SUM_EN
    check("sum_ones", out_sum, 12'hFFE);
`endif
    pop();
    for (int k = 0; k < 5; k++) push(12'(12'h100 + k), 0);
    check("pre_resync_err", sync_err, 0);
    push(12'hABC, 1);
    check("resync_err", sync_err, 1);
    exp_frame[11:0] = 12'hABC;
    for (int k = 1; k < 16; k++) exp_frame[k*12 +: 12] = 12'(12'h300 + k);
    for (int k = 1; k < 15; k++) begin
      push(12'(12'h300 + k), 0);
      if (k == 1) check("resync_err_clear", sync_err, 0);
    end
    check("resync_not_early", out_valid, 0);
    push(12'h30F, 0);
    check("resync_full", out_valid, 1);
    check("resync_data", out_data, exp_frame);
`ifdef AFFINE_OP2_LOADER_SUM_EN
    check("sum_resync", out_sum, 12'(((12'hABC + 16'h2D00 + 16'd120)) >> 3));
`endif
    pop();
    for (int k = 0; k < 16; k++) begin
      exp_frame[k*12 +: 12] = 12'(12'h200 + 7 * k);
      while ($urandom_range(0, 1) == 0) tick(1);
      push(12'(12'h200 + 7 * k), 0);
    end
    check("rand_valid", out_valid, 1);
    check("rand_data", out_data, exp_frame);
    in_valid = 1;
    in_data = 12'h555;
    tick(3);
    in_valid = 0;
    check("full_ignore_data", out_data, exp_frame);
    check("full_ignore_valid", out_valid, 1);
    pop();
    for (int k = 0; k < 16; k++) exp_frame[k*12 +: 12] = 12'(12'h040 + k);
    for (int k = 0; k < 16; k++) push(12'(12'h040 + k), 0);
    check("after_ignore", out_data, exp_frame);
    do_reset();
    check("rst_full_valid", out_valid, 0);
    check("rst_full_ready", in_ready, 1);
    check("rst_full_data", out_data, 0);
`ifdef AFFINE_OP2_LOADER_SUM_EN
    check("rst_full_sum", out_sum, 0);
`endif
    for (int k = 0; k < 8; k++) push(12'(12'h700 + k), 0);
    do_reset();
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_ready", in_ready, 1);
    check("rst_mid_data", out_data, 0);
    for (int k = 0; k < 16; k++) exp_frame[k*12 +: 12] = 12'(12'h0A0 + k);
    for (int k = 0; k < 15; k++) push(12'(12'h0A0 + k), 0);
    check("fresh_not_early", out_valid, 0);
    push(12'h0AF, 0);
    check("fresh_valid", out_valid, 1);
    check("fresh_data", out_data, exp_frame);
    check("fresh_err", sync_err, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/affine_op2_loader.md
Name: affine_op2_loader

Overview:
- Write-side feeder for the second-stage 16-input affine adder.
- Accepts a serial stream of 12-bit first-stage results, one word per valid/ready handshake.
- Collects NWORDS words into a parallel buffer, then presents the whole frame as one flattened vector, held with a valid/ready handshake until the adder side consumes it.

Parameters:
- WIDTH, 12, bits per data word.
- NWORDS, 16, words per frame; power of two, at least 2.
- IDXW, 4, index counter width; equals log2(NWORDS).

Ports:
- clock  in  1  single rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_data  in  WIDTH  serial data word.
- in_valid  in  1  in_data is valid.
- in_first  in  1  marks the word as word 0 of a frame; qualified by in_valid.
- in_ready  out  1  loader accepts a word this cycle.
- out_data  out  WIDTH*NWORDS  frame; word k is at bits [k*WIDTH +: WIDTH], so word 0 is at the LSBs.
- out_valid  out  1  frame complete and stable.
- out_ready  in  1  consumer takes the frame this cycle.
- sync_err  out  1  one-cycle pulse on a frame resync.

Behaviour:
- Reset values: state=FILL, idx=0, out_valid=0, in_ready=1, sync_err=0, out_data all zero.
- States:
  - FILL: in_ready=1, out_valid=0.
  - FULL: in_ready=0, out_valid=1.
- Accept rule: an accept is in_valid && in_ready. On an accept, in_data is written to word[idx] at the next edge and idx increments.
- FILL to FULL: happens on the accept with idx==NWORDS-1. out_valid rises the cycle after that accept. Latency from the last word to out_valid is 1 cycle.
- FULL to FILL: happens on out_valid && out_ready, with idx cleared to 0. in_ready rises the next cycle. There is no bubble-free overlap; the single buffer is intentional.
- out_data stays constant for the whole time out_valid=1. Buffer words are only written in FILL.
- Resync: an accept with in_first=1 while idx!=0 does the following.
  - Discards the partial frame.
  - Writes the word to word[0] and sets idx=1.
  - Pulses sync_err for one cycle.
- in_first=1 with idx==0 is normal and raises no error.
- in_first on word 0 is not required: a stream with no in_first just fills sequentially.
- Inputs that are not accepted (in_valid=0, or in_ready=0) have no effect. The producer must hold in_data until the word is accepted.
- Reset asserted mid-frame or in FULL returns the block to the reset state next edge. The partial or held frame is lost and out_valid drops.
- idx wrap: idx is never incremented past NWORDS-1. The transition to FULL clears it to 0.
- out_ready while out_valid=0 is ignored.

Optional Feature:
- Macro: AFFINE_OP2_LOADER_SUM_EN.
- When defined:
  - Adds output port out_sum [WIDTH-1:0].
  - A (WIDTH+IDXW)-bit accumulator is loaded with in_data on a word-0 accept (idx==0 or a resync) and adds in_data on every other accept. All words are treated as unsigned.
  - out_sum = acc[WIDTH+2:3]: the sum shifted right by 3 and trimmed to WIDTH bits. This equals the second-stage adder output.
  - out_sum is valid and held while out_valid=1. It resets to 0.
  - Intended as a golden value for checking the adder stage.
- When undefined: no port and no accumulator. The remaining behaviour is identical.

Decomposition:
- Package affine_pkg holds:
  - constants AFFINE_WIDTH=12 and AFFINE_NWORDS=16;
  - the state enum {ST_FILL, ST_FULL};
  - the word typedef logic [AFFINE_WIDTH-1:0].
- No sub-module; the FSM, counter and buffer form one module. The optional accumulator is an inline block.

Test Plan:
- Reset, then send 16 words 1..16 with back-to-back valid and out_ready=0. Required: out_valid=1 one cycle after word 16, in_ready=0, word k = k+1, and the frame holds for 10 cycles. With SUM_EN, out_sum = 136>>3 = 17.
- Pulse out_ready for one cycle with out_valid=1. Required: out_valid=0 and in_ready=1 next cycle; the next 16 words 0xFFF give out_data all ones. With SUM_EN, out_sum = 65520>>3 = 8190, trimmed to 12 bits = 0xFFE.
- Send 5 words, then a word 0xABC with in_first=1. Required: sync_err pulses once, word 0 = 0xABC, and the frame completes after 15 more accepts (not 10).
- Toggle in_valid randomly at 50% across 16 accepts. Required: no word lost or duplicated, and word order is preserved.
- Assert reset after 8 words, or during FULL. Required: next cycle out_valid=0, in_ready=1, out_data=0, idx=0, and a fresh 16-word frame completes normally.
- Assert in_valid during FULL with in_ready=0. Required: buffer unchanged and no accept is counted.
